// File: rtl/mnist_img_streamer_if.sv
// Signals between the image streamer and its pixel memory, label memory and CNN core.
// The streamer is the master; memories and core sit on the slave side.
interface mnist_img_streamer_if #(
   parameter int unsigned ADDR_W = 20
);
   logic [ADDR_W-1:0] pix_addr;
   logic              pix_rd;
   logic [7:0]        pix_rdata;
   logic [9:0]        lbl_addr;
   logic [3:0]        lbl_rdata;
   logic              cnn_rst_n;
   logic [7:0]        data_in;
   logic [3:0]        decision;
   logic              valid_out_6;

   modport master (
      output pix_addr, pix_rd, lbl_addr, cnn_rst_n, data_in,
      input  pix_rdata, lbl_rdata, decision, valid_out_6
   );

   modport slave (
      input  pix_addr, pix_rd, lbl_addr, cnn_rst_n, data_in,
      output pix_rdata, lbl_rdata, decision, valid_out_6
   );
endinterface

// File: rtl/mnist_img_streamer.sv
// Streams stored MNIST images into a CNN core, one pixel per clock, and scores each
// decision against a stored label, accumulating a hit count per run.
module mnist_img_streamer #(
   parameter int unsigned NUM_IMG = 1000,
   parameter int unsigned IMG_PIX = 784,
   parameter int unsigned ADDR_W  = 20,
   parameter int unsigned CLR_CYC = 2,
   parameter int unsigned TIMEOUT = 4096
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   mnist_img_streamer_if.master bus,
   output logic                 busy,
   output logic                 img_done,
   output logic                 img_hit,
   output logic [9:0]           img_idx,
   output logic [9:0]           hit_cnt,
   output logic                 timeout_err,
   output logic                 done
);

   localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StStream,
      StWait,
      StScore,
      StDone
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pix_addr_q, pix_addr_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [9:0]        pix_cnt_q, pix_cnt_d;
   logic [TmoW-1:0]   tmo_cnt_q, tmo_cnt_d;
   logic [3:0]        dec_q, dec_d;
   logic [9:0]        img_idx_q, img_idx_d;
   logic [9:0]        hit_cnt_q, hit_cnt_d;
   logic              tmo_err_q, tmo_err_d;
   logic              rd_q;
   logic [7:0]        data_q;
   logic              hit;

   assign hit = (dec_q == bus.lbl_rdata);

   always_comb begin
      state_d    = state_q;
      pix_addr_d = pix_addr_q;
      base_d     = base_q;
      pix_cnt_d  = pix_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      dec_d      = dec_q;
      img_idx_d  = img_idx_q;
      hit_cnt_d  = hit_cnt_q;
      tmo_err_d  = tmo_err_q;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d   = StClear;
               img_idx_d = '0;
               hit_cnt_d = '0;
               tmo_err_d = 1'b0;
               base_d    = '0;
               pix_cnt_d = '0;
            end
         end

         StClear: begin
            // base_q tracks img_idx*IMG_PIX, advanced by one image on every SCORE
            pix_addr_d = base_q;
            if (pix_cnt_q == 10'(CLR_CYC - 1)) begin
               state_d   = StStream;
               pix_cnt_d = '0;
            end else begin
               pix_cnt_d = pix_cnt_q + 10'd1;
            end
         end

         StStream: begin
            pix_addr_d = pix_addr_q + ADDR_W'(1);
            if (pix_cnt_q == 10'(IMG_PIX - 1)) begin
               state_d   = StWait;
               pix_cnt_d = '0;
               tmo_cnt_d = '0;
            end else begin
               pix_cnt_d = pix_cnt_q + 10'd1;
            end
         end

         StWait: begin
            if (bus.valid_out_6) begin
               dec_d   = bus.decision;
               state_d = StScore;
            end else if (tmo_cnt_q == TmoW'(TIMEOUT - 1)) begin
               // 4'hF can never match a digit label, so a timeout always scores a miss
               dec_d     = 4'hF;
               tmo_err_d = 1'b1;
               state_d   = StScore;
            end else begin
               tmo_cnt_d = tmo_cnt_q + TmoW'(1);
            end
         end

         StScore: begin
            if (hit && (hit_cnt_q != 10'h3FF)) begin
               hit_cnt_d = hit_cnt_q + 10'd1;
            end
            if (img_idx_q == 10'(NUM_IMG - 1)) begin
               state_d = StDone;
            end else begin
               img_idx_d = img_idx_q + 10'd1;
               base_d    = base_q + ADDR_W'(IMG_PIX);
               pix_cnt_d = '0;
               state_d   = StClear;
            end
         end

         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         pix_addr_q <= '0;
         base_q     <= '0;
         pix_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         dec_q      <= '0;
         img_idx_q  <= '0;
         hit_cnt_q  <= '0;
         tmo_err_q  <= 1'b0;
         rd_q       <= 1'b0;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         pix_addr_q <= pix_addr_d;
         base_q     <= base_d;
         pix_cnt_q  <= pix_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         dec_q      <= dec_d;
         img_idx_q  <= img_idx_d;
         hit_cnt_q  <= hit_cnt_d;
         tmo_err_q  <= tmo_err_d;
         // read data arrives one cycle after pix_rd; only then is it captured
         rd_q       <= (state_q == StStream);
         if (rd_q) begin
            data_q <= bus.pix_rdata;
         end
      end
   end

   assign bus.pix_addr  = pix_addr_q;
   assign bus.pix_rd    = (state_q == StStream);
   assign bus.lbl_addr  = img_idx_q;
   assign bus.cnn_rst_n = (state_q != StClear);
   assign bus.data_in   = data_q;

   assign busy        = (state_q != StIdle) && (state_q != StDone);
   assign done        = (state_q == StDone);
   assign img_done    = (state_q == StScore);
   assign img_hit     = (state_q == StScore) && hit;
   assign img_idx     = img_idx_q;
   assign hit_cnt     = hit_cnt_q;
   assign timeout_err = tmo_err_q;

endmodule

// File: tb/tb_mnist_img_streamer.sv
// Directed bench for mnist_img_streamer: behavioural pixel/label memories and a CNN
// model that can echo the label, miss on odd images, or never answer.
module tb_mnist_img_streamer;

   localparam int unsigned NUM_IMG = 4;
   localparam int unsigned IMG_PIX = 784;
   localparam int unsigned ADDR_W  = 20;
   localparam int unsigned CLR_CYC = 2;
   localparam int unsigned TIMEOUT = 16;
   // model answers this many cycles after the core reset is released
   localparam int          VLAT    = 790;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       busy, img_done, img_hit, timeout_err, done;
   logic [9:0] img_idx, hit_cnt;

   int         n_checks = 0;
   int         n_err = 0;
   int         mode;
   logic       inj_valid;
   int         model_cnt;
   logic [3:0] labels [NUM_IMG];

   mnist_img_streamer_if #(.ADDR_W(ADDR_W)) bus ();

   mnist_img_streamer #(
      .NUM_IMG(NUM_IMG),
      .IMG_PIX(IMG_PIX),
      .ADDR_W (ADDR_W),
      .CLR_CYC(CLR_CYC),
      .TIMEOUT(TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bus        (bus),
      .busy       (busy),
      .img_done   (img_done),
      .img_hit    (img_hit),
      .img_idx    (img_idx),
      .hit_cnt    (hit_cnt),
      .timeout_err(timeout_err),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (bus.pix_rd) bus.pix_rdata <= bus.pix_addr[7:0];
      bus.lbl_rdata <= labels[bus.lbl_addr[1:0]];
      if (rst || !bus.cnn_rst_n) model_cnt <= 0;
      else model_cnt <= model_cnt + 1;
   end

   always_comb begin
      bus.valid_out_6 = inj_valid || ((mode != 2) && (model_cnt == VLAT));
      bus.decision    = labels[bus.lbl_addr[1:0]];
      if (mode == 1 && bus.lbl_addr[0]) bus.decision = bus.decision + 4'd1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic reset_checks(input string tag);
      check({tag, " cnn_rst_n"},   32'(bus.cnn_rst_n), 1);
      check({tag, " pix_rd"},      32'(bus.pix_rd), 0);
      check({tag, " busy"},        32'(busy), 0);
      check({tag, " done"},        32'(done), 0);
      check({tag, " timeout_err"}, 32'(timeout_err), 0);
      check({tag, " img_done"},    32'(img_done), 0);
      check({tag, " img_hit"},     32'(img_hit), 0);
      check({tag, " pix_addr"},    32'(bus.pix_addr), 0);
      check({tag, " data_in"},     32'(bus.data_in), 0);
      check({tag, " img_idx"},     32'(img_idx), 0);
      check({tag, " hit_cnt"},     32'(hit_cnt), 0);
   endtask

   // Entered during CLEAR; follows one whole image cycle by cycle.
   task automatic stream_image(input string tag, input int img, input int exp_done_j,
                               input logic exp_hit, input bit inject);
      int                lows = 0;
      int                rd_bad = 0;
      int                dat_bad = 0;
      int                done_j = -1;
      logic              hit_seen = 1'b0;
      logic [ADDR_W-1:0] base = ADDR_W'(img * IMG_PIX);
      logic [ADDR_W-1:0] a;
      while (bus.cnn_rst_n === 1'b0 && lows < 20) begin
         lows++;
         tick();
      end
      check({tag, " clr_cycles"}, lows, CLR_CYC);
      check({tag, " first_addr"}, 32'(bus.pix_addr), 32'(base));
      for (int j = 0; j < 830; j++) begin
         if (j < IMG_PIX && (bus.pix_rd !== 1'b1 || img_idx !== 10'(img))) rd_bad++;
         if (j >= IMG_PIX && j < IMG_PIX + 6 && bus.pix_rd !== 1'b0) rd_bad++;
         if (j >= 2 && j < IMG_PIX + 6) begin
            a = (j < IMG_PIX + 2) ? base + ADDR_W'(j - 2) : base + ADDR_W'(IMG_PIX - 1);
            if (bus.data_in !== a[7:0]) dat_bad++;
         end
         if (img_done === 1'b1 && done_j < 0) begin
            done_j   = j;
            hit_seen = img_hit;
         end
         if (inject && j == 100) begin
            inj_valid = 1'b1;
            start     = 1'b1;
         end
         if (inject && j == 101) begin
            inj_valid = 1'b0;
            start     = 1'b0;
         end
         tick();
      end
      check({tag, " rd_window"}, rd_bad, 0);
      check({tag, " data_stream"}, dat_bad, 0);
      check({tag, " done_latency"}, done_j, exp_done_j);
      check({tag, " hit"}, 32'(hit_seen), 32'(exp_hit));
   endtask

   task automatic wait_img(input string tag, input int img, input logic exp_hit);
      int n = 0;
      while (img_done !== 1'b1 && n < 3000) begin
         n++;
         tick();
      end
      check({tag, " done_seen"}, 32'(img_done), 1);
      check({tag, " hit"}, 32'(img_hit), 32'(exp_hit));
      check({tag, " idx"}, 32'(img_idx), img);
      tick();
   endtask

   initial begin
      int n;
      int exp_hits;
      labels[0] = 4'd7;
      labels[1] = 4'd2;
      labels[2] = 4'd1;
      labels[3] = 4'd9;
      mode      = 0;
      inj_valid = 1'b0;
      start     = 1'b0;
      rst       = 1'b1;
      tick();
      tick();
      reset_checks("reset");
      rst = 1'b0;
      tick();

      // Run A: model echoes label; valid/start injected during image 0's stream
      mode = 0;
      pulse_start();
      check("A busy", 32'(busy), 1);
      stream_image("A img0", 0, VLAT + 1, 1'b1, 1'b1);
      for (int i = 1; i < NUM_IMG; i++) begin
         wait_img($sformatf("A img%0d", i), i, 1'b1);
      end
      check("A hit_cnt", 32'(hit_cnt), 4);
      check("A done", 32'(done), 1);
      check("A busy_end", 32'(busy), 0);
      check("A timeout_err", 32'(timeout_err), 0);
      for (int k = 0; k < 5; k++) tick();
      check("A hit_cnt_hold", 32'(hit_cnt), 4);
      check("A done_hold", 32'(done), 1);

      // Run B: odd images answered wrongly, restarted from DONE
      mode = 1;
      pulse_start();
      check("B done_clr", 32'(done), 0);
      check("B hit_cnt_clr", 32'(hit_cnt), 0);
      exp_hits = 0;
      for (int i = 0; i < NUM_IMG; i++) begin
         wait_img($sformatf("B img%0d", i), i, (i % 2) == 0);
         if ((i % 2) == 0) exp_hits++;
         check($sformatf("B hit_cnt%0d", i), 32'(hit_cnt), exp_hits);
      end
      check("B done", 32'(done), 1);

      // Run C: core never answers
      mode = 2;
      pulse_start();
      check("C timeout_err_clr", 32'(timeout_err), 0);
      stream_image("C img0", 0, IMG_PIX + TIMEOUT, 1'b0, 1'b0);
      check("C timeout_err", 32'(timeout_err), 1);
      for (int i = 1; i < NUM_IMG; i++) begin
         wait_img($sformatf("C img%0d", i), i, 1'b0);
         check($sformatf("C sticky%0d", i), 32'(timeout_err), 1);
      end
      check("C done", 32'(done), 1);
      check("C hit_cnt", 32'(hit_cnt), 0);

      // Run D: reset during image 1's stream, then a clean restart
      mode = 0;
      pulse_start();
      check("D timeout_err_clr", 32'(timeout_err), 0);
      wait_img("D img0", 0, 1'b1);
      n = 0;
      while (bus.pix_rd !== 1'b1 && n < 20) begin
         n++;
         tick();
      end
      check("D img1_streaming", 32'(bus.pix_rd), 1);
      for (int k = 0; k < 50; k++) tick();
      rst = 1'b1;
      tick();
      reset_checks("D midrst");
      rst = 1'b0;
      tick();
      check("D idle_after_rst", 32'(busy), 0);
      pulse_start();
      stream_image("D img0", 0, VLAT + 1, 1'b1, 1'b0);
      for (int i = 1; i < NUM_IMG; i++) begin
         wait_img($sformatf("D img%0d", i), i, 1'b1);
      end
      check("D hit_cnt", 32'(hit_cnt), 4);
      check("D done", 32'(done), 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
